rf_write_arbiter: RTL
=====================

// Module: rf_write_arbiter
// PURPOSE
//  Shares the 4x8 accumulator register file's single write port among NUM_REQ requesters
//  (ALU writeback, memory load, immediate load). Uses round-robin arbitration with an optional
//  bounded burst lock, then drives registered write_reg/write_data/write_reg_en and CZN flags.
//  Sits between the datapath producers and the register file.
// PARAMETERS
//  NUM_REQ      3  number of write requesters (2..8)
//  WORD_LENGTH  8  data width; matches register file
//  MAX_BURST    4  max consecutive locked transfers per grant (1..15)
// PORTS
//  clk            in   1                  clock, all state on posedge
//  rst            in   1                  reset, asynchronous, active-high
//  req_valid      in   NUM_REQ            requester i has a write pending
//  req_lock       in   NUM_REQ            requester i asks to keep the grant after this transfer
//  req_addr       in   2*NUM_REQ          target register; slice [2i+1:2i]
//  req_data       in   WORD_LENGTH*NUM_REQ  write data; slice i
//  req_carry      in   NUM_REQ            carry flag accompanying requester i's data
//  req_ready      out  NUM_REQ            one-hot or zero; transfer when valid&ready
//  rf_write_reg   out  2                  to register file write_reg
//  rf_write_data  out  WORD_LENGTH        to register file write_data
//  rf_write_en    out  1                  to register file write_reg_en
//  czn_out        out  3                  {N,Z,C} of last committed write; [0]=C [1]=Z [2]=N
//  grant_id       out  $clog2(NUM_REQ)    index of requester owning last committed write
// BEHAVIOUR
//  - Reset (async): state=ARB, rr_ptr=0, burst_cnt=0, rf_write_en=0, rf_write_reg=0,
//    rf_write_data=0, czn_out=0, grant_id=0, req_ready=0.
//  - req_ready is combinational from state/req_valid. Handshake completes when valid&ready.
//    Requester must hold addr/data/carry/lock stable while valid=1 and ready=0.
//  - Latency: handshake in cycle T -> rf_write_en=1 with matching reg/data in T+1 (one cycle),
//    czn_out/grant_id update same edge. rf_write_en=0 on any cycle following no handshake.
//  - ARB state: winner = first i with req_valid[i] scanning rr_ptr, rr_ptr+1, ... mod NUM_REQ;
//    req_ready[winner]=1. On handshake: owner=winner. If req_lock[winner]=1 and MAX_BURST>1,
//    go LOCKED with burst_cnt=1; else rr_ptr=(winner+1) mod NUM_REQ and stay in ARB.
//    No valid -> no ready, rr_ptr unchanged.
//  - LOCKED state: req_ready[owner]=req_valid[owner]; all others 0.
//    On handshake, burst_cnt++. Release to ARB (rr_ptr=owner+1 mod NUM_REQ, burst_cnt=0) when:
//    req_lock[owner]=0 on the handshake, or burst_cnt reaches MAX_BURST after it.
//    Owner valid=0 while LOCKED: release to ARB next edge, same rr_ptr update, bubble cycle (no grant).
//  - Flags: C=req_carry of winner; Z=(data==0); N=data[WORD_LENGTH-1] (two's-complement sign).
//  - Only one ready at a time; multiple valid requesters never both transfer in one cycle.
//  - Starvation bound: a valid requester is granted within (NUM_REQ-1)*MAX_BURST+NUM_REQ cycles.
//  - rst mid-burst: immediately to reset values; in-flight write output dropped.
// CONFIGURATION
//  - RF_WR_ARB_STATS_EN defined: adds output grant_count [16*NUM_REQ], a per-requester 16-bit
//    saturating count of completed handshakes (holds at 16'hFFFF), cleared by rst.
//  - Not defined: port absent, no counters synthesized; all other behaviour identical.
// STRUCTURE
//  - Package rf_arb_pkg: typedef enum logic {ARB, LOCKED} arb_state_t; CZN bit index constants
//    C_IDX=0, Z_IDX=1, N_IDX=2; RF_ADDR_W=2; RF_WORD_LENGTH=8.
//  - Sub-module rr_priority_picker #(N): inputs req[N], ptr; outputs found, idx (combinational
//    rotate-and-find-first). Instantiated once for the ARB winner search.
// TESTING
//  1. Reset with req_valid=3'b111 held -> all outputs 0 while rst=1; first grant after release to req 0.
//  2. req_valid=3'b111, lock=0, 6 cycles -> grant order 0,1,2,0,1,2; rf_write_en high T+1 each.
//  3. req1 writes addr 2 data 8'h80 carry 1 -> next cycle rf_write_reg=2, data=8'h80, czn_out=3'b101.
//  4. req2 lock=1 continuously, MAX_BURST=4, all valid -> four req2 writes, then req0 granted.
//  5. req0 locked, drops valid after 2 writes -> one bubble cycle (en=0), then req1 granted.
//  6. STATS_EN: 70000 req0 handshakes -> grant_count[0] saturates at 16'hFFFF; others 0.

Source files
------------

// File: rtl/rf_write_arbiter_pkg.sv
// Shared types and constants for the register-file write arbiter.
package rf_arb_pkg;

  typedef enum logic {ARB, LOCKED} arb_state_t;

  // Bit positions inside the {N,Z,C} flag vector
  localparam int C_IDX = 0;
  localparam int Z_IDX = 1;
  localparam int N_IDX = 2;

  localparam int RF_ADDR_W      = 2;
  localparam int RF_WORD_LENGTH = 8;

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational round-robin search: first asserted req starting at ptr, wrapping mod N.
module rr_priority_picker #(
  parameter int N  = 3,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic          found,
  output logic [PW-1:0] idx
);

  // Rotate-and-find-first, keeping the earliest hit in ptr order
  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < N; k++) begin
      int c;
      c = int'(ptr) + k;
      if (c >= N) c = c - N;
      if (!found && req[c]) begin
        found = 1'b1;
        idx   = PW'(c);
      end
    end
  end

endmodule

// File: rtl/rf_write_arbiter.sv
// Round-robin write-port arbiter with bounded burst lock for the 4x8 register file.
// Optional feature: define RF_WR_ARB_STATS_EN to add per-requester saturating
// handshake counters on output grant_count.
module rf_write_arbiter
  import rf_arb_pkg::*;
#(
  parameter int NUM_REQ     = 3,
  parameter int WORD_LENGTH = 8,
  parameter int MAX_BURST   = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [NUM_REQ-1:0]             req_lock,
  input  logic [RF_ADDR_W*NUM_REQ-1:0]   req_addr,
  input  logic [WORD_LENGTH*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]             req_carry,
  output logic [NUM_REQ-1:0]             req_ready,
  output logic [RF_ADDR_W-1:0]           rf_write_reg,
  output logic [WORD_LENGTH-1:0]         rf_write_data,
  output logic                           rf_write_en,
  output logic [2:0]                     czn_out,
`ifdef RF_WR_ARB_STATS_EN
  output logic [16*NUM_REQ-1:0]          grant_count,
`endif
  output logic [$clog2(NUM_REQ)-1:0]     grant_id
);

  localparam int PW = $clog2(NUM_REQ);
  localparam bit BURST_EN = (MAX_BURST > 1);

  arb_state_t    state;
  logic [PW-1:0] rr_ptr;
  logic [PW-1:0] owner;
  logic [3:0]    burst_cnt;

  logic          rr_found;
  logic [PW-1:0] rr_idx;
  logic [PW-1:0] sel_p0;
  logic          vld_p0;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] i);
    next_ptr = (int'(i) == NUM_REQ - 1) ? '0 : i + 1'b1;
  endfunction

  function automatic logic [2:0] czn_of(input logic [WORD_LENGTH-1:0] d, input logic c);
    logic signed [WORD_LENGTH-1:0] sd;
    sd            = signed'(d);
    czn_of        = '0;
    czn_of[C_IDX] = c;
    czn_of[Z_IDX] = (d == '0);
    czn_of[N_IDX] = (sd < 0);
  endfunction

  rr_priority_picker #(.N(NUM_REQ), .PW(PW)) u_picker (
    .req   (req_valid),
    .ptr   (rr_ptr),
    .found (rr_found),
    .idx   (rr_idx)
  );

  // ---- stage p0: grant selection and handshake detection ----
  // Ready is one-hot from the current owner/winner; held low while in reset
  always_comb begin
    req_ready = '0;
    sel_p0    = (state == LOCKED) ? owner : rr_idx;
    if (!rst) begin
      if (state == LOCKED) req_ready[owner] = req_valid[owner];
      else if (rr_found)   req_ready[rr_idx] = 1'b1;
    end
    vld_p0 = |(req_valid & req_ready);
  end

  // Arbitration state: round-robin pointer, burst ownership and burst length
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ARB;
      rr_ptr    <= '0;
      owner     <= '0;
      burst_cnt <= '0;
    end else if (state == ARB) begin
      if (vld_p0) begin
        owner <= sel_p0;
        if (BURST_EN && req_lock[sel_p0]) begin
          state     <= LOCKED;
          burst_cnt <= 4'd1;
        end else begin
          rr_ptr <= next_ptr(sel_p0);
        end
      end
    end else begin
      if (!req_valid[owner] || (vld_p0 &&
          (!req_lock[owner] || (burst_cnt + 4'd1) >= 4'(MAX_BURST)))) begin
        state     <= ARB;
        rr_ptr    <= next_ptr(owner);
        burst_cnt <= '0;
      end else if (vld_p0) begin
        burst_cnt <= burst_cnt + 4'd1;
      end
    end
  end

  // ---- stage p1: registered write port and flags ----
  // Commit the granted transfer to the register file one cycle after handshake
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rf_write_en   <= 1'b0;
      rf_write_reg  <= '0;
      rf_write_data <= '0;
      czn_out       <= '0;
      grant_id      <= '0;
    end else begin
      rf_write_en <= vld_p0;
      if (vld_p0) begin
        rf_write_reg  <= req_addr[RF_ADDR_W*int'(sel_p0) +: RF_ADDR_W];
        rf_write_data <= req_data[WORD_LENGTH*int'(sel_p0) +: WORD_LENGTH];
        czn_out       <= czn_of(req_data[WORD_LENGTH*int'(sel_p0) +: WORD_LENGTH],
                                req_carry[sel_p0]);
        grant_id      <= sel_p0;
      end
    end
  end

`ifdef RF_WR_ARB_STATS_EN
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    sat_inc16 = (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_stats
    // Count completed handshakes per requester, sticking at full scale
    always_ff @(posedge clk or posedge rst) begin
      if (rst)                                 grant_count[16*g +: 16] <= '0;
      else if (vld_p0 && int'(sel_p0) == g)    grant_count[16*g +: 16] <= sat_inc16(grant_count[16*g +: 16]);
    end
  end
`endif

endmodule
